// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator result/BCD stage
package calc_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so counters always have at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector: add 3 when the digit is 5 or more
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_W'(5)) begin
            digit_o = digit_i + BCD_W'(3);
        end
    end

endmodule

// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - captures the signed ALU result and converts its magnitude
// to packed BCD with an iterative shift-and-add-3 engine for the display driver.
module alu_result_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH-1:0]          result,
    input  logic                      div_zero,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      neg,
    output logic                      err
);

    localparam int BW    = BCD_W * DIGITS;
    localparam int CNT_W = clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BW-1:0]      scr_q, scr_d;
    logic               neg_r_q, neg_r_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]    abs_val;
    logic [BW-1:0]       scr_adj;
    logic [BW+WIDTH-1:0] shifted;

    // Two's-complement negate; the most negative value maps onto 2^(WIDTH-1) unsigned.
    assign abs_val = result[WIDTH-1] ? (~result + WIDTH'(1)) : result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scr_q[g*BCD_W +: BCD_W]),
            .digit_o (scr_adj[g*BCD_W +: BCD_W])
        );
    end

    assign shifted = {scr_adj, mag_q} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        neg_r_d = neg_r_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (div_zero) begin
                        bcd_d   = '0;
                        neg_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mag_d   = abs_val;
                        neg_r_d = result[WIDTH-1];
                        scr_d   = '0;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                scr_d = shifted[BW+WIDTH-1:WIDTH];
                mag_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                    neg_d   = neg_r_q;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            scr_q   <= '0;
            neg_r_q <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            neg_r_q <= neg_r_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb/tb_alu_result_bcd.sv - self-checking bench for alu_result_bcd
module tb_alu_result_bcd;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] result;
    logic        div_zero;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        neg;
    logic        err;

    int checks;
    int errors;

    alu_result_bcd dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .result   (result),
        .div_zero (div_zero),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .neg      (neg),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        logic [19:0] exp_bcd;
        logic        exp_neg;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of |value| by repeated division.
    task automatic model(input logic [15:0] r, input logic dz,
                         output logic [19:0] b, output logic n, output logic e);
        int v;
        int m;
        b = '0;
        if (dz) begin
            n = 1'b0;
            e = 1'b1;
        end else begin
            v = int'($signed(r));
            m = (v < 0) ? -v : v;
            n = (v < 0);
            e = 1'b0;
            for (int d = 0; d < 5; d++) begin
                b[d*4 +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
    endtask

    // Issue one start and wait (bounded) for done; inputs are scrambled after the accepting edge.
    task automatic do_conv(input logic [15:0] r, input logic dz,
                           output int lat, output int busy_cnt);
        logic seen;
        @(negedge clk);
        start    = 1'b1;
        result   = r;
        div_zero = dz;
        @(negedge clk);
        start    = 1'b0;
        result   = 16'($urandom);
        div_zero = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] r, input logic dz,
                                 input logic [19:0] eb, input logic en, input logic ee);
        int lat;
        int bc;
        do_conv(r, dz, lat, bc);
        check({tag, " latency"}, 32'(lat), dz ? 32'd1 : 32'd17);
        check({tag, " bcd"}, 32'(bcd), 32'(eb));
        check({tag, " neg"}, 32'(neg), 32'(en));
        check({tag, " err"}, 32'(err), 32'(ee));
        check({tag, " busy_cycles"}, 32'(bc), dz ? 32'd1 : 32'd17);
        @(negedge clk);
        check({tag, " done_pulse_end"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int done_cnt;
        int busy_seen;
        logic [19:0] mb;
        logic        mn;
        logic        me;
        logic [15:0] rr;
        logic        rdz;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'd1234,  1'b0, 20'h01234, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF,  1'b0, 20'h00001, 1'b1, 1'b0};
        vecs[2] = '{16'h8000,  1'b0, 20'h32768, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF,  1'b0, 20'h32767, 1'b0, 1'b0};
        vecs[4] = '{16'd9999,  1'b0, 20'h09999, 1'b0, 1'b0};
        vecs[5] = '{16'd0,     1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[6] = '{16'd0,     1'b1, 20'h00000, 1'b0, 1'b1};
        vecs[7] = '{16'd1234,  1'b0, 20'h01234, 1'b0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        result   = '0;
        div_zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset outputs", {8'd0, bcd, 1'b0, neg, err, done, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].res, vecs[i].dz,
                          vecs[i].exp_bcd, vecs[i].exp_neg, vecs[i].exp_err);
        end

        // Start while busy must be dropped.
        @(negedge clk);
        start = 1'b1; result = 16'd1234; div_zero = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; result = 16'd5;
        @(negedge clk);
        start = 1'b0;
        done_cnt  = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                done_cnt++;
                check("ignore bcd", 32'(bcd), 32'h01234);
            end
            if (i >= 20 && busy) busy_seen++;
            @(negedge clk);
        end
        check("ignore done_count", 32'(done_cnt), 32'd1);
        check("ignore no_requeue", 32'(busy_seen), 32'd0);

        // Reset mid-conversion discards the partial result.
        @(negedge clk);
        start = 1'b1; result = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("midconv outputs held", 32'(bcd), 32'h01234);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset state", {8'd0, bcd, 1'b0, neg, err, done, busy}, 32'd0);
        repeat (25) @(negedge clk);
        check("midreset no_done", {30'd0, done, busy}, 32'd0);
        run_and_check("after_reset", 16'd42, 1'b0, 20'h00042, 1'b0, 1'b0);

        // Randomised conversions against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            rr  = 16'($urandom);
            rdz = ($urandom_range(0, 7) == 0);
            model(rr, rdz, mb, mn, me);
            do_conv(rr, rdz, lat, bc);
            check($sformatf("rand%0d latency", i), 32'(lat), rdz ? 32'd1 : 32'd17);
            check($sformatf("rand%0d result", i), {10'd0, bcd, neg, err}, {10'd0, mb, mn, me});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
Downstream stage of the calculator ALU. It captures the signed 16-bit ALU result and the divide-by-zero flag on a start pulse. It converts the magnitude to packed BCD with an iterative double-dabble (shift-and-add-3) engine and presents sign, five digits and an error indication to the display driver. The done pulse marks a new, stable display value.

Parameters:
WIDTH, 16, bit width of the ALU result (two's complement).
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; no other clock domains
start  input  1  request conversion of result/div_zero sampled this cycle
result  input  WIDTH  signed ALU output S
div_zero  input  1  ALU flag (divide by zero)
busy  output  1  conversion in progress; start ignored while high
done  output  1  one-cycle pulse: bcd/neg/err updated and valid
bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0], most significant digit at top
neg  output  1  result was negative
err  output  1  last capture had div_zero set

Behaviour:
- Reset (reset=1 at a rising edge): state IDLE, busy=0, done=0, bcd=0, neg=0, err=0, counter=0. Reset wins over every other event, including mid-conversion; a partial result is discarded and never shown.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k, div_zero=0:
  - mag = |result| as an unsigned WIDTH-bit value; -2^(WIDTH-1) maps to 2^(WIDTH-1) with no overflow.
  - neg_r = result[WIDTH-1]; scratch BCD=0; counter=0; go to SHIFT.
- IDLE, start=1 at edge k, div_zero=1: go directly to DONE. Registered outputs at that edge: err=1, neg=0, bcd=0.
- IDLE, start=0: hold; outputs keep their last values.
- SHIFT: one iteration per clock, WIDTH iterations total (edges k+1..k+WIDTH).
  - Each iteration: every BCD digit >= 5 gets +3, then {bcd, mag} shifts left by 1.
  - At the edge where counter reaches WIDTH-1, the final iteration completes. At that same edge: bcd, neg, err(=0) register to the outputs and the state goes to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally. A start seen in DONE is ignored.
- Latency, start edge k to done high:
  - Normal path: done is high in the cycle after edge k+WIDTH (k+16 for default).
  - Error path: done is high in the cycle after edge k.
- busy=1 in SHIFT and DONE, 0 in IDLE. A start while busy=1 is dropped, not queued.
- Outputs bcd/neg/err change only on the edge that enters DONE (or reset). They are stable between done pulses.
- result/div_zero are sampled only on the accepting edge. Later input changes do not affect the conversion in flight.
- Zero converts to bcd=0, neg=0. No negative zero exists.

Decomposition:
- Shared package calc_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_W=4
  - default WIDTH/DIGITS constants
  - counter width function clog2(WIDTH)
- Sub-module bcd_add3: combinational 4-bit "if >=5 then +3" digit corrector. It is instantiated DIGITS times via generate inside the SHIFT datapath.
- Remaining logic (FSM, counter, magnitude, output registers) lives in alu_result_bcd.

Test Plan:
- start with result=16'd1234, div_zero=0 -> done exactly 17 cycles after the start edge; bcd=20'h01234, neg=0, err=0; busy high for 17 cycles.
- result=16'hFFFF (-1) -> bcd=20'h00001, neg=1. result=16'h8000 (-32768) -> bcd=20'h32768, neg=1. result=16'h7FFF -> bcd=20'h32767, neg=0.
- result=16'd9999 (ALU default case) -> bcd=20'h09999. result=0 -> bcd=0, neg=0.
- div_zero=1 with result=0 -> done in the cycle after the start edge; err=1, bcd=0, neg=0. A following normal conversion clears err to 0.
- Start re-asserted with result=16'd5 while busy -> ignored; the first conversion (16'd1234) completes unchanged with one done pulse.
- Reset asserted at SHIFT iteration 8 -> next cycle busy=0, done=0, bcd=0. A following conversion of 16'd42 gives bcd=20'h00042 with no residue.
